bcd_subtractor: RTL and testbench
=================================

// Module: bcd_subtractor
// PURPOSE
//  Multi-digit BCD subtractor computing |a - b| with a sign flag.
//  Serial: one digit per clock, LSD first, through a single shared digit slice.
//  Negative results get a second pass (ten's-complement negate), so the
//    output is always magnitude + sign.
//  Start/busy/done handshake; feeds the seven-segment display path
//    alongside the BCD adder.
// PARAMETERS
//  DIGITS  4  number of BCD digits per operand and result (>=1)
// PORTS
//  clk    in   1         system clock, rising edge
//  rst    in   1         asynchronous reset, active-high
//  start  in   1         request; sampled only in IDLE
//  a      in   4*DIGITS  minuend, packed BCD, digit 0 = bits[3:0]
//  b      in   4*DIGITS  subtrahend, packed BCD
//  busy   out  1         high in SUB and NEG states
//  done   out  1         one-cycle pulse when diff/neg/err are updated
//  diff   out  4*DIGITS  magnitude |a-b|, packed BCD
//  neg    out  1         1 when a < b
//  err    out  1         1 when any digit of latched a or b > 9
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE; busy=0, done=0, diff=0, neg=0, err=0.
//    Internal registers clear.
//  Reset mid-operation: aborts immediately. No done pulse.
//  IDLE, start=1 at edge E0: latch a, b; digit index=0; borrow=0.
//    Any digit > 9 -> DONE with err=1, diff=0, neg=0 (done after E1).
//    Otherwise -> SUB.
//  SUB: each edge processes digit i.
//    t = a_i - b_i - borrow.
//    If t < 0: r_i = t + 10, borrow = 1; else r_i = t, borrow = 0.
//    After digit DIGITS-1:
//      final borrow=0 -> DONE.
//      final borrow=1 -> NEG (index=0, borrow=0).
//  NEG: each edge computes r_i = 0 - r_i - borrow, same digit rule.
//    After the last digit -> DONE with neg=1.
//  DONE: lasts 1 cycle. done=1; diff/neg/err registered on the edge entering
//    DONE. Then -> IDLE unconditionally.
//  Latency from E0 to done high: DIGITS edges (a>=b), 2*DIGITS edges (a<b),
//    1 edge (err).
//  start while busy or in DONE: ignored; no queuing.
//  a, b may change after E0 without effect.
//  diff/neg/err hold their values between done pulses.
//  Equal operands: diff=0, neg=0. There is never a negative zero.
//  Arithmetic: digit slice uses a 5-bit signed intermediate. Every result
//    digit is 0..9; no carry-out.
// STRUCTURE
//  Package bcd_pkg holds:
//    BCD_W=4, BCD_MAX=4'd9, BCD_BASE=5'd10
//    state type {IDLE, SUB, NEG, DONE}
//  Sub-module bcd_digit_sub (combinational): inputs x, y (4b), bin;
//    outputs d (4b), bout. One instance shared by the SUB and NEG passes.
//  Top holds the FSM, digit index counter, operand/result shift registers,
//    and output registers.
// TESTING (DIGITS=4)
//  1. a=4321, b=1234, start -> done 4 cycles after E0; diff=3087, neg=0,
//     err=0.
//  2. a=1234, b=4321 -> busy for 8 cycles; diff=3087, neg=1.
//  3. a=1000, b=0001 -> borrow chain, diff=0999, neg=0; a=0000, b=9999 ->
//     diff=9999, neg=1.
//  4. a=5555, b=5555 -> diff=0000, neg=0; start pulsed again mid-op ->
//     ignored, exactly one done.
//  5. a=12A4 (digit 0xA), b=0000 -> done after 1 edge; err=1, diff=0000,
//     neg=0.
//  6. rst=1 during NEG of case 2 -> all outputs 0, no done; a fresh start
//     afterwards completes correctly.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants and the FSM state type for the serial BCD subtractor.
package bcd_pkg;

    localparam int          BCD_W    = 4;
    localparam logic [3:0]  BCD_MAX  = 4'd9;
    localparam logic [4:0]  BCD_BASE = 5'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/bcd_digit_sub.sv
// Single BCD digit subtract-with-borrow slice: d = x - y - bin, wrapped into 0..9.
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] x,
    input  logic [BCD_W-1:0] y,
    input  logic             bin,
    output logic [BCD_W-1:0] d,
    output logic             bout
);

    logic signed [4:0] t;
    logic        [4:0] t_adj;

    // Signed 5-bit difference; a negative result is folded back by adding ten.
    always_comb begin
        t     = $signed({1'b0, x}) - $signed({1'b0, y}) - $signed({4'b0000, bin});
        t_adj = 5'(t);
        bout  = 1'b0;
        if (t < 0) begin
            t_adj = 5'(t) + BCD_BASE;
            bout  = 1'b1;
        end
        d = t_adj[BCD_W-1:0];
    end

endmodule

// File: rtl/bcd_subtractor.sv
// Serial multi-digit BCD subtractor producing |a - b| plus a sign flag.
// One digit per clock, LSD first; a negative intermediate is ten's-complement
// negated in a second pass through the same digit slice.
module bcd_subtractor
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   diff,
    output logic                  neg,
    output logic                  err
);

    localparam int W  = BCD_W * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t          state_reg, state_next;
    logic [W-1:0]    a_reg, b_reg, r_reg;
    logic [IW-1:0]   idx_reg;
    logic            borrow_reg;
    logic            bad_reg;

    logic [DIGITS-1:0] digit_bad;
    logic [BCD_W-1:0]  slice_x, slice_y, slice_d;
    logic              slice_bout;
    logic              last_digit;
    logic [W-1:0]      r_shift;

    // Per-digit range check on the incoming operands, evaluated when latching.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_check
        assign digit_bad[gi] = (a[gi*BCD_W +: BCD_W] > BCD_MAX) ||
                               (b[gi*BCD_W +: BCD_W] > BCD_MAX);
    end

    // The negate pass computes 0 - r_i - borrow; the subtract pass a_i - b_i - borrow.
    assign slice_x    = (state_reg == NEG) ? '0 : a_reg[BCD_W-1:0];
    assign slice_y    = (state_reg == NEG) ? r_reg[BCD_W-1:0] : b_reg[BCD_W-1:0];
    assign last_digit = (idx_reg == IW'(DIGITS - 1));
    // New digit enters at the top so that after DIGITS shifts digit 0 sits at the bottom.
    assign r_shift    = (r_reg >> BCD_W) | (W'(slice_d) << (W - BCD_W));

    bcd_digit_sub u_slice (
        .x    (slice_x),
        .y    (slice_y),
        .bin  (borrow_reg),
        .d    (slice_d),
        .bout (slice_bout)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: if (start) state_next = SUB;
            SUB: begin
                busy = 1'b1;
                if (bad_reg)         state_next = DONE;
                else if (last_digit) state_next = slice_bout ? NEG : DONE;
            end
            NEG: begin
                busy = 1'b1;
                if (last_digit) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand/result shift registers, digit counter, borrow and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            r_reg      <= '0;
            idx_reg    <= '0;
            borrow_reg <= 1'b0;
            bad_reg    <= 1'b0;
            diff       <= '0;
            neg        <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (start) begin
                    a_reg      <= a;
                    b_reg      <= b;
                    r_reg      <= '0;
                    idx_reg    <= '0;
                    borrow_reg <= 1'b0;
                    bad_reg    <= |digit_bad;
                end
                SUB: begin
                    if (bad_reg) begin
                        diff <= '0;
                        neg  <= 1'b0;
                        err  <= 1'b1;
                    end else begin
                        a_reg      <= a_reg >> BCD_W;
                        b_reg      <= b_reg >> BCD_W;
                        r_reg      <= r_shift;
                        borrow_reg <= slice_bout;
                        if (last_digit) begin
                            idx_reg <= '0;
                            if (slice_bout) begin
                                // Wrapped result: restart the borrow for the negate pass.
                                borrow_reg <= 1'b0;
                            end else begin
                                diff <= r_shift;
                                neg  <= 1'b0;
                                err  <= 1'b0;
                            end
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end
                end
                NEG: begin
                    r_reg      <= r_shift;
                    borrow_reg <= slice_bout;
                    if (last_digit) begin
                        idx_reg <= '0;
                        diff    <= r_shift;
                        neg     <= 1'b1;
                        err     <= 1'b0;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_subtractor.sv
// Scoreboard bench for bcd_subtractor (DIGITS=4): directed vectors, decoupled monitor.
module tb_bcd_subtractor;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    typedef struct {
        logic [W-1:0] diff;
        logic         neg;
        logic         err;
        int           lat;
        int           c0;
        string        name;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, neg, err;
    logic [W-1:0] diff;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    bcd_subtractor #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .neg   (neg),
        .err   (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Issue one operation; optionally poke start again while busy. Waits for the scoreboard to drain.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] ed, input logic en, input logic ee,
                          input int lat, input string name, input bit poke);
        exp_t e;
        int   n;
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = '1; b = '1;   // operands must not matter after latching
        e.diff = ed; e.neg = en; e.err = ee; e.lat = lat; e.c0 = cyc; e.name = name;
        sb.push_back(e);
        if (poke) begin
            @(negedge clk); start = 1'b1; a = 16'h9999; b = 16'h0001;
            @(negedge clk); start = 1'b0;
        end
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s timeout: queue=%0d required=0", name, sb.size());
            sb.delete();
        end
        // Extra idle cycles: catches a second (unexpected) done pulse.
        repeat (4) @(negedge clk);
        tests++;
        if (diff !== ed || neg !== en) begin
            fails++;
            $display("FAIL %s hold: diff=%h neg=%b required diff=%h neg=%b", name, diff, neg, ed, en);
        end
    endtask

    initial begin
        fork
            // Monitor: pop and compare on every done pulse.
            forever begin
                exp_t e;
                @(negedge clk);
                if (!rst && done) begin
                    if (sb.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_done: done=1 at cycle %0d required none", cyc);
                    end else begin
                        e = sb.pop_front();
                        tests += 4;
                        if (diff !== e.diff) begin
                            fails++; $display("FAIL %s diff: got %h required %h", e.name, diff, e.diff);
                        end
                        if (neg !== e.neg) begin
                            fails++; $display("FAIL %s neg: got %b required %b", e.name, neg, e.neg);
                        end
                        if (err !== e.err) begin
                            fails++; $display("FAIL %s err: got %b required %b", e.name, err, e.err);
                        end
                        if (cyc - e.c0 !== e.lat) begin
                            fails++; $display("FAIL %s latency: got %0d required %0d", e.name, cyc - e.c0, e.lat);
                        end
                        $display("[TB] %s a-b -> diff=%h neg=%b err=%b lat=%0d", e.name, diff, neg, err, cyc - e.c0);
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        tests++;
        if ({busy, done, diff, neg, err} !== '0) begin
            fails++;
            $display("FAIL reset_state: busy=%b done=%b diff=%h neg=%b err=%b required all 0", busy, done, diff, neg, err);
        end
        rst = 1'b0;

        run_op(16'h4321, 16'h1234, 16'h3087, 1'b0, 1'b0, 4, "t1_pos",      1'b0);
        run_op(16'h1234, 16'h4321, 16'h3087, 1'b1, 1'b0, 8, "t2_neg",      1'b0);
        run_op(16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0, 4, "t3_chain",    1'b0);
        run_op(16'h0000, 16'h9999, 16'h9999, 1'b1, 1'b0, 8, "t3_negmax",   1'b0);
        run_op(16'h5555, 16'h5555, 16'h0000, 1'b0, 1'b0, 4, "t4_equal",    1'b1);
        run_op(16'h9999, 16'h0000, 16'h9999, 1'b0, 1'b0, 4, "pos_max",     1'b0);
        run_op(16'h0500, 16'h0499, 16'h0001, 1'b0, 1'b0, 4, "near_equal",  1'b0);
        run_op(16'h0499, 16'h0500, 16'h0001, 1'b1, 1'b0, 8, "near_neg",    1'b0);
        run_op(16'h12A4, 16'h0000, 16'h0000, 1'b0, 1'b1, 1, "t5_err",      1'b0);

        // Reset during the negate pass: outputs clear, no done.
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({busy, done, diff, neg, err} !== '0) begin
            fails++;
            $display("FAIL t6_abort: busy=%b done=%b diff=%h neg=%b err=%b required all 0", busy, done, diff, neg, err);
        end
        $display("[TB] t6_abort reset in NEG -> busy=%b diff=%h err=%b", busy, diff, err);
        @(negedge clk);
        rst = 1'b0;

        run_op(16'h1234, 16'h4321, 16'h3087, 1'b1, 1'b0, 8, "t6_restart", 1'b0);

        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL final_queue: size=%0d required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
